// File: rtl/fib_pair_serializer.sv
// Pair-to-word serializer for a double-rate Fibonacci source. Pairs are pushed into a
// small word FIFO and emitted one word per cycle; an output-side checker verifies every
// emitted word is the modular sum of the two words before it.
module fib_pair_serializer #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_num2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_num,
  output logic         seq_err,
  output logic [15:0]  out_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  prev1_q, prev1_d;  // most recently popped word
  logic [W-1:0]  prev2_q, prev2_d;  // word popped before prev1
  logic [1:0]    hist_q, hist_d;
  logic          err_q, err_d;
  logic [15:0]   out_cnt_q, out_cnt_d;

  logic          push, pop;
  logic [W-1:0]  expected;
  logic          mismatch;

  // Flow control uses registered occupancy only; rst masks both sides during reset.
  assign in_ready  = !rst && (cnt_q <= CW'(DEPTH - 2));
  assign out_valid = !rst && (cnt_q != '0);
  assign out_num   = mem[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Wrap-around of the sum is legal, so truncation to W bits is intended.
  assign expected  = prev1_q + prev2_q;
  assign mismatch  = pop && (hist_q == 2'd2) && (out_num != expected);

  assign seq_err   = err_q;
  assign out_cnt   = out_cnt_q;

  // Next-state for pointers, occupancy, checker history, error flag and pop counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
    hist_d    = hist_q;
    err_d     = err_q | mismatch;
    out_cnt_d = out_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(2);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(2);
      2'b01:   cnt_d = cnt_q - CW'(1);
      2'b11:   cnt_d = cnt_q + CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (pop) begin
      prev2_d   = prev1_q;
      prev1_d   = out_num;
      out_cnt_d = out_cnt_q + 16'd1;
      if (hist_q != 2'd2) hist_d = hist_q + 2'd1;
    end
  end

  // Control and checker state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      prev1_q   <= '0;
      prev2_q   <= '0;
      hist_q    <= 2'd0;
      err_q     <= 1'b0;
      out_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
      hist_q    <= hist_d;
      err_q     <= err_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Word storage; contents are don't-care after reset so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q]           <= in_num;
      mem[wr_ptr_q + AW'(1)]  <= in_num2;
    end
  end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed bench for fib_pair_serializer: stream order, backpressure, simultaneous
// push/pop, arithmetic wrap, sticky violation and mid-operation reset.
module tb_fib_pair_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_num;
  logic [15:0] in_num2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_num;
  logic        seq_err;
  logic [15:0] out_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] popped [$];
  logic [15:0] exp_q  [$];
  logic        rand_done;

  always #5 clk = ~clk;

  fib_pair_serializer #(
    .W     (16),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_num2   (in_num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .seq_err   (seq_err),
    .out_cnt   (out_cnt)
  );

  // Inputs change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) popped.push_back(out_num);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_seq_err", seq_err, 0);
    check("post_rst_out_cnt", out_cnt, 0);
    popped.delete();
    @(posedge clk); #1;
  endtask

  // Called just after a posedge; returns just after the edge that accepted the pair.
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_num   = a;
    in_num2  = b;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_words(input string tag);
    check({tag, "_len"}, popped.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
      check($sformatf("%s_w%0d", tag, i), popped[i], exp_q[i]);
  endtask

  initial begin
    logic [15:0] fa, fb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_num    = '0;
    in_num2   = '0;
    out_ready = 1'b0;
    rand_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic stream.
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd3);
    push_pair(16'd5, 16'd8);
    push_pair(16'd13, 16'd21);
    push_pair(16'd34, 16'd55);
    drain();
    exp_q = {16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55};
    check_words("basic");
    check("basic_seq_err", seq_err, 0);
    check("basic_out_cnt", out_cnt, 10);

    // Backpressure fill.
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd3);
    @(negedge clk);
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_out_valid", out_valid, 1);
    check("bp_head", out_num, 1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_num   = 16'd5;
    in_num2  = 16'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_held_in_ready", in_ready, 0);
    check("bp_held_out_cnt", out_cnt, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_cnt4_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_cnt3_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_cnt2_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    exp_q = {16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    check_words("bp");
    check("bp_out_cnt", out_cnt, 6);

    // Simultaneous push and pop at cnt=2 leaves cnt=3.
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd1, 16'd1);
    out_ready = 1'b1;
    push_pair(16'd2, 16'd3);
    out_ready = 1'b0;
    @(negedge clk);
    check("sim_in_ready", in_ready, 0);
    check("sim_head", out_num, 1);
    check("sim_out_cnt", out_cnt, 1);
    @(posedge clk); #1;
    drain();
    exp_q = {16'd1, 16'd1, 16'd2, 16'd3};
    check_words("sim");
    check("sim_final_cnt", out_cnt, 4);

    // Pointer wrap with random consumer stalls over 20 pairs.
    do_reset();
    exp_q.delete();
    fa = 16'd1;
    fb = 16'd1;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          push_pair(fa, fb);
          exp_q.push_back(fa);
          exp_q.push_back(fb);
          fa = fa + fb;
          fb = fa + fb;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          if (!rand_done) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check_words("rand");
    check("rand_seq_err", seq_err, 0);
    check("rand_out_cnt", out_cnt, 40);

    // Arithmetic wrap: 46368 + 28657 = 75025 -> 9489.
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd17711, 16'd28657);
    push_pair(16'd46368, 16'd9489);
    drain();
    exp_q = {16'd17711, 16'd28657, 16'd46368, 16'd9489};
    check_words("wrap");
    check("wrap_seq_err", seq_err, 0);

    // Violation: 4 != 1 + 2, flag rises the cycle after 4 is popped.
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd4);
    out_ready = 1'b1;
    exp_q = {16'd1, 16'd1, 16'd2, 16'd4};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("viol_head%0d", i), out_num, exp_q[i]);
      check($sformatf("viol_clear%0d", i), seq_err, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("viol_set", seq_err, 1);
    @(posedge clk); #1;
    push_pair(16'd6, 16'd10);
    drain();
    check("viol_sticky", seq_err, 1);

    // Mid-operation reset with cnt=3 and seq_err=1.
    out_ready = 1'b0;
    push_pair(16'd16, 16'd26);
    out_ready = 1'b1;
    push_pair(16'd42, 16'd68);
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_err", seq_err, 1);
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd3);
    drain();
    exp_q = {16'd1, 16'd1, 16'd2, 16'd3};
    check_words("fresh");
    check("fresh_seq_err", seq_err, 0);
    check("fresh_out_cnt", out_cnt, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fib_pair_serializer.md
Name: fib_pair_serializer

Overview:
- Downstream stage of the double-rate Fibonacci generator. Accepts two consecutive 16-bit sequence words per transfer and buffers them in a small word FIFO.
- Emits one word per cycle on a valid/ready stream, so a single-rate consumer can use the double-rate source.
- An output-side checker confirms every emitted word obeys F(n) = F(n-1) + F(n-2) mod 2^W.
- Raises a sticky error flag on the first violation and counts emitted words.

Parameters:
- W, 16, data word width in bits.
- DEPTH, 4, FIFO capacity in words; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  a word pair is presented.
- in_ready  output  1  the block can accept a pair this cycle.
- in_num  input  W  first word of the pair (older in the sequence).
- in_num2  input  W  second word of the pair (newer in the sequence).
- out_valid  output  1  out_num holds a valid word.
- out_ready  input  1  the consumer takes out_num this cycle.
- out_num  output  W  FIFO head word.
- seq_err  output  1  sticky sequence-violation flag.
- out_cnt  output  16  number of words popped, wraps at 2^16.

Behaviour:
- Handshakes:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
- Reset (rst=1 at a clock edge), regardless of in-flight data:
  - FIFO pointers and occupancy go to 0; out_valid=0, in_ready=0 during the reset cycle.
  - seq_err=0, out_cnt=0, checker history cleared.
  - FIFO storage contents are don't-care.
  - First cycle after reset: in_ready=1.
- Occupancy:
  - cnt is a registered count, 0..DEPTH, width clog2(DEPTH)+1.
  - in_ready = (DEPTH - cnt >= 2), derived from registered cnt only, with no combinational path from out_ready.
  - out_valid = (cnt != 0); out_num = mem[rd_ptr], combinational read of the head.
- Push:
  - Writes in_num at wr_ptr and in_num2 at wr_ptr+1 (mod DEPTH); wr_ptr advances by 2 with wrap.
  - Order is preserved: in_num pops before in_num2.
- Pop: rd_ptr advances by 1 with wrap.
- Simultaneous push and pop in one cycle: cnt_next = cnt + 2 - 1.
- Push only: cnt + 2. Pop only: cnt - 1.
- A push with in_ready=0 never occurs, because in_valid is ignored when in_ready=0.
- Latency: a pushed pair's first word is visible on out_num the cycle after the push edge. Throughput is 1 word/cycle at the output.
- A producer that stalls in_valid while in_ready=0 must hold in_num and in_num2 stable. The block does not capture data without a handshake.
- Checker state: prev1, prev2 (W bits each) and hist (0, 1 or 2 = number of valid history words). All update only on pop.
  - hist<2: no check; shift the popped word into history; hist++.
  - hist==2: expected = prev1 + prev2, truncated to W bits (wrap-around is legal, not an error). If out_num != expected, set seq_err=1 on the next edge. Always shift history.
- seq_err is cleared only by rst.
- Each pop increments out_cnt; it wraps 65535 -> 0.
- No state machine beyond the occupancy counter and the checker hist counter (states 0, 1, 2; 2 is absorbing until reset).

Test Plan:
- Basic stream: reset, then feed pairs (1,1),(2,3),(5,8),(13,21),(34,55) with out_ready=1 -> out_num 1,1,2,3,5,8,13,21,34,55 on consecutive pops; seq_err=0; out_cnt=10.
- Backpressure fill: out_ready=0, offer pairs (1,1),(2,3),(5,8) -> first two accepted, cnt=4, in_ready=0, third pair held. Then raise out_ready -> in_ready returns to 1 when cnt<=2; order 1,1,2,3,5,8 is preserved.
- Simultaneous push/pop at cnt=2: occupancy goes 2->3 with one push and one pop in the same cycle. Pointer wrap exercised over 20 pairs with random out_ready; output still a valid sequence.
- Arithmetic wrap: feed (17711,28657),(46368,9489) -> no seq_err; 9489 = 75025 mod 65536 is accepted.
- Violation: feed (1,1),(2,4) -> seq_err rises the cycle after 4 is popped and stays 1 through further valid pairs until rst.
- Mid-operation reset: assert rst with cnt=3 and seq_err=1 -> next cycle out_valid=0, seq_err=0, out_cnt=0, in_ready=1. A fresh stream (1,1),(2,3) then checks cleanly with no stale history.
